ifetch_queue: RTL and testbench

- Instruction prefetch stage directly upstream of the f8 cpu core.
- Fetches 16-bit words from program memory and buffers the bytes in a circular byte queue.
- Presents the 24-bit instruction window starting at the core's iread_addr: iread_data[7:0] is the opcode byte, little-endian.
- Handles sequential consumption, redirects (jumps, calls, reset vector) and memory back-pressure.

---
 rtl/ifetch_queue_if.sv | 27 ++
 rtl/ifetch_queue.sv | 145 ++++++++++++++
 tb/tb_ifetch_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Bundles the core-facing instruction window and the program-memory request
// port of the instruction prefetch queue.
interface ifetch_queue_if;
  // Memory side: a request transfers on a cycle with mem_rd=1 and mem_ready=1.
  // While mem_ready=0 the requester holds mem_rd and mem_addr. mem_valid has no
  // back-pressure and returns one word for each accepted request, no earlier
  // than the cycle after the transfer. Core side: iread_data is meaningful
  // only when ivalid=1, and the core holds iread_addr while ivalid=0.
  logic [15:0] iread_addr;
  logic [23:0] iread_data;
  logic        ivalid;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic        mem_valid;

  modport slave (
    input  iread_addr, mem_ready, mem_data, mem_valid,
    output iread_data, ivalid, mem_addr, mem_rd
  );

  modport master (
    output iread_addr, mem_ready, mem_data, mem_valid,
    input  iread_data, ivalid, mem_addr, mem_rd
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches 16-bit words into a circular byte queue
// and presents the 3-byte instruction window at the core's read address.
module ifetch_queue #(
  parameter int          QDEPTH   = 8,
  parameter logic [15:0] RESET_PC = 16'h4000
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_queue_if.slave bus
);

  localparam int IW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = CW + 1;

  logic [15:0]   qbase_q, qbase_d;
  logic [IW-1:0] rdptr_q, rdptr_d;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [15:0]   faddr_q, faddr_d;
  logic          outstanding_q, outstanding_d;
  logic          stale_q, stale_d;
  logic          drop_low_q, drop_low_d;
  logic [7:0]    q_q [QDEPTH];
  logic [7:0]    q_d [QDEPTH];

  logic [15:0]   d;
  logic [1:0]    d2;
  logic          hit;
  logic [CW-1:0] avail;
  logic          ivalid;
  logic          room;
  logic          mem_rd;
  logic          accept;
  logic          resp;
  logic [CW-1:0] npush;
  logic [IW-1:0] ridx0, ridx1, ridx2;
  logic [IW-1:0] widx0, widx1;

  // Sums handed in never reach 2*QDEPTH+1, so two conditional subtracts suffice
  // even when QDEPTH is not a power of two.
  function automatic logic [IW-1:0] wrap_idx(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    if (r >= SW'(2 * QDEPTH)) r = r - SW'(2 * QDEPTH);
    else if (r >= SW'(QDEPTH)) r = r - SW'(QDEPTH);
    return r[IW-1:0];
  endfunction

  always_comb begin
    d      = bus.iread_addr - qbase_q;
    d2     = d[1:0];
    hit    = (d <= 16'd3) && (d <= 16'(qcnt_q));
    avail  = qcnt_q - CW'(d2);
    ivalid = reset && hit && (avail >= CW'(3));
    ridx0  = wrap_idx(SW'(rdptr_q) + SW'(d2));
    ridx1  = wrap_idx(SW'(rdptr_q) + SW'(d2) + SW'(1));
    ridx2  = wrap_idx(SW'(rdptr_q) + SW'(d2) + SW'(2));
    widx0  = wrap_idx(SW'(rdptr_q) + SW'(qcnt_q));
    widx1  = wrap_idx(SW'(rdptr_q) + SW'(qcnt_q) + SW'(1));
    // Space is reserved for the in-flight word as well as the new one.
    room   = (SW'(qcnt_q) + (outstanding_q ? SW'(2) : SW'(0)) + SW'(2)) <= SW'(QDEPTH);
    mem_rd = reset && hit && (!outstanding_q || bus.mem_valid) && room;
    accept = mem_rd && bus.mem_ready;
    resp   = bus.mem_valid && outstanding_q;
  end

  assign bus.ivalid     = ivalid;
  assign bus.iread_data = ivalid ? {q_q[ridx2], q_q[ridx1], q_q[ridx0]} : 24'h0;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_addr   = faddr_q;

  always_comb begin
    qbase_d       = qbase_q;
    rdptr_d       = rdptr_q;
    qcnt_d        = qcnt_q;
    faddr_d       = faddr_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    drop_low_d    = drop_low_q;
    q_d           = q_q;
    npush         = '0;

    if (!hit) begin
      qbase_d    = bus.iread_addr;
      rdptr_d    = '0;
      qcnt_d     = '0;
      faddr_d    = {bus.iread_addr[15:1], 1'b0};
      drop_low_d = bus.iread_addr[0];
      // A response landing in the redirect cycle is simply discarded; one that
      // has not arrived yet must be dropped when it does.
      if (resp) begin
        outstanding_d = 1'b0;
        stale_d       = 1'b0;
      end else if (outstanding_q) begin
        stale_d = 1'b1;
      end
    end else begin
      qbase_d = qbase_q + d;
      rdptr_d = wrap_idx(SW'(rdptr_q) + SW'(d2));
      if (resp) begin
        outstanding_d = 1'b0;
        if (stale_q) begin
          stale_d = 1'b0;
        end else if (drop_low_q) begin
          q_d[widx0] = bus.mem_data[15:8];
          npush      = CW'(1);
          drop_low_d = 1'b0;
        end else begin
          q_d[widx0] = bus.mem_data[7:0];
          q_d[widx1] = bus.mem_data[15:8];
          npush      = CW'(2);
          drop_low_d = 1'b0;
        end
      end
      if (accept) begin
        faddr_d       = faddr_q + 16'd2;
        outstanding_d = 1'b1;
      end
      qcnt_d = qcnt_q - CW'(d2) + npush;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qbase_q       <= RESET_PC;
      rdptr_q       <= '0;
      qcnt_q        <= '0;
      faddr_q       <= {RESET_PC[15:1], 1'b0};
      outstanding_q <= 1'b0;
      stale_q       <= 1'b0;
      drop_low_q    <= RESET_PC[0];
      for (int i = 0; i < QDEPTH; i++) q_q[i] <= '0;
    end else begin
      qbase_q       <= qbase_d;
      rdptr_q       <= rdptr_d;
      qcnt_q        <= qcnt_d;
      faddr_q       <= faddr_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      drop_low_q    <= drop_low_d;
      q_q           <= q_d;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a byte-addressed program memory whose byte
// value equals the low address byte, driven with per-cycle expected outputs.
module tb_ifetch_queue;
  localparam int QDEPTH = 8;

  logic clk = 1'b0;
  logic reset;

  ifetch_queue_if bus();

  ifetch_queue #(.QDEPTH(QDEPTH), .RESET_PC(16'h4000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        rdy;
    logic        exp_rd;
    logic [15:0] exp_maddr;
    logic        exp_iv;
    logic [23:0] exp_data;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected accepted request addresses.
  logic [15:0] exp_q[$];
  bit          sb_on = 1'b0;

  // Memory model: one response slot, lat extra cycles beyond one.
  bit          m_busy   = 1'b0;
  int          m_wait   = 0;
  logic [15:0] m_addr   = 16'h0;
  int          lat      = 0;
  bit          inj_late = 1'b0;

  vec_t tbl[18];

  function automatic vec_t mk(input logic [15:0] a, input logic r, input logic er,
                              input logic [15:0] ema, input logic eiv, input logic [23:0] ed);
    vec_t v;
    v.addr = a; v.rdy = r; v.exp_rd = er; v.exp_maddr = ema; v.exp_iv = eiv; v.exp_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] addr, input logic rdy);
    @(negedge clk);
    if (inj_late) begin
      bus.mem_valid = 1'b1;
      bus.mem_data  = 16'hDEAD;
      inj_late      = 1'b0;
    end else if (m_busy && m_wait == 0) begin
      bus.mem_valid = 1'b1;
      bus.mem_data  = {m_addr[7:0] | 8'h01, m_addr[7:0]};
      m_busy        = 1'b0;
    end else begin
      if (m_busy) m_wait--;
      bus.mem_valid = 1'b0;
      bus.mem_data  = 16'h0;
    end
    bus.iread_addr = addr;
    bus.mem_ready  = rdy;
    #1;
    if (bus.mem_rd && bus.mem_ready) begin
      m_busy = 1'b1;
      m_wait = lat;
      m_addr = bus.mem_addr;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: actual=%h required=none", bus.mem_addr);
        end else begin
          check("sb_addr", 32'(bus.mem_addr), 32'(exp_q.pop_front()));
        end
      end
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    step(v.addr, v.rdy);
    check({tag, "_rd"}, 32'(bus.mem_rd), 32'(v.exp_rd));
    if (v.exp_rd) check({tag, "_maddr"}, 32'(bus.mem_addr), 32'(v.exp_maddr));
    check({tag, "_iv"}, 32'(bus.ivalid), 32'(v.exp_iv));
    check({tag, "_data"}, 32'(bus.iread_data), 32'(v.exp_data));
    check({tag, "_qcap"}, 32'(dut.qcnt_q <= 4'(QDEPTH)), 32'(1));
  endtask

  task automatic enter_reset();
    reset         = 1'b0;
    m_busy        = 1'b0;
    inj_late      = 1'b0;
    lat           = 0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = 16'h0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset(input logic [15:0] addr);
    @(posedge clk);
    #2;
    bus.iread_addr = addr;
    reset          = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    bus.iread_addr = 16'h4000;
    bus.mem_ready  = 1'b1;
    bus.mem_valid  = 1'b0;
    bus.mem_data   = 16'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_iv", 32'(bus.ivalid), 32'(0));
    check("rst_rd", 32'(bus.mem_rd), 32'(0));
    check("rst_data", 32'(bus.iread_data), 32'(0));

    // Fill from reset, then sequential d=1 streaming with a one-cycle memory.
    tbl[0]  = mk(16'h4000, 1, 1, 16'h4000, 0, 24'h000000);
    tbl[1]  = mk(16'h4000, 1, 1, 16'h4002, 0, 24'h000000);
    tbl[2]  = mk(16'h4000, 1, 1, 16'h4004, 0, 24'h000000);
    tbl[3]  = mk(16'h4000, 1, 1, 16'h4006, 1, 24'h020100);
    tbl[4]  = mk(16'h4001, 1, 0, 16'h0000, 1, 24'h030201);
    tbl[5]  = mk(16'h4002, 1, 0, 16'h0000, 1, 24'h040302);
    tbl[6]  = mk(16'h4003, 1, 1, 16'h4008, 1, 24'h050403);
    tbl[7]  = mk(16'h4004, 1, 0, 16'h0000, 1, 24'h060504);
    tbl[8]  = mk(16'h4005, 1, 1, 16'h400A, 1, 24'h070605);
    tbl[9]  = mk(16'h4006, 1, 0, 16'h0000, 1, 24'h080706);
    tbl[10] = mk(16'h4007, 1, 1, 16'h400C, 1, 24'h090807);
    tbl[11] = mk(16'h4008, 1, 0, 16'h0000, 1, 24'h0A0908);
    tbl[12] = mk(16'h4009, 1, 1, 16'h400E, 1, 24'h0B0A09);
    tbl[13] = mk(16'h400A, 1, 0, 16'h0000, 1, 24'h0C0B0A);
    tbl[14] = mk(16'h400B, 1, 1, 16'h4010, 1, 24'h0D0C0B);
    tbl[15] = mk(16'h400C, 1, 0, 16'h0000, 1, 24'h0E0D0C);
    tbl[16] = mk(16'h400D, 1, 1, 16'h4012, 1, 24'h0F0E0D);
    tbl[17] = mk(16'h400E, 1, 0, 16'h0000, 1, 24'h100F0E);

    release_reset(16'h4000);
    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("row%0d", i));

    // Stale response across an odd redirect, back-pressure, then wrap at FFFE.
    enter_reset();
    release_reset(16'h4000);
    exp_q = '{16'h4000, 16'h4002, 16'h4004, 16'h4006, 16'h5000, 16'h5002, 16'h5004,
              16'h5006, 16'h5008, 16'h500A, 16'h500C, 16'hFFFE, 16'h0000, 16'h0002,
              16'h0004};
    sb_on = 1'b1;
    apply(mk(16'h4000, 1, 1, 16'h4000, 0, 24'h000000), "st0");
    apply(mk(16'h4000, 1, 1, 16'h4002, 0, 24'h000000), "st1");
    apply(mk(16'h4000, 1, 1, 16'h4004, 0, 24'h000000), "st2");
    lat = 1;
    apply(mk(16'h4000, 1, 1, 16'h4006, 1, 24'h020100), "st3");
    lat = 0;
    apply(mk(16'h5001, 1, 0, 16'h0000, 0, 24'h000000), "st4_redir");
    apply(mk(16'h5001, 1, 1, 16'h5000, 0, 24'h000000), "st5");
    apply(mk(16'h5001, 1, 1, 16'h5002, 0, 24'h000000), "st6");
    apply(mk(16'h5001, 1, 1, 16'h5004, 0, 24'h000000), "st7");
    apply(mk(16'h5001, 1, 1, 16'h5006, 1, 24'h030201), "st8");

    apply(mk(16'h5003, 0, 0, 16'h0000, 1, 24'h050403), "bp0");
    apply(mk(16'h5005, 0, 1, 16'h5008, 1, 24'h070605), "bp1");
    apply(mk(16'h5006, 0, 1, 16'h5008, 0, 24'h000000), "bp2");
    apply(mk(16'h5006, 0, 1, 16'h5008, 0, 24'h000000), "bp3");
    apply(mk(16'h5006, 0, 1, 16'h5008, 0, 24'h000000), "bp4");
    apply(mk(16'h5006, 1, 1, 16'h5008, 0, 24'h000000), "bp5");
    apply(mk(16'h5006, 1, 1, 16'h500A, 0, 24'h000000), "bp6");
    apply(mk(16'h5006, 1, 1, 16'h500C, 1, 24'h080706), "bp7");

    apply(mk(16'hFFFE, 1, 0, 16'h0000, 0, 24'h000000), "wr0_redir");
    apply(mk(16'hFFFE, 1, 1, 16'hFFFE, 0, 24'h000000), "wr1");
    apply(mk(16'hFFFE, 1, 1, 16'h0000, 0, 24'h000000), "wr2");
    apply(mk(16'hFFFE, 1, 1, 16'h0002, 0, 24'h000000), "wr3");
    apply(mk(16'hFFFE, 1, 1, 16'h0004, 1, 24'h00FFFE), "wr4");
    apply(mk(16'hFFFF, 1, 0, 16'h0000, 1, 24'h0100FF), "wr5");
    apply(mk(16'h0000, 1, 0, 16'h0000, 1, 24'h020100), "wr6");
    check("sb_drain1", 32'(exp_q.size()), 32'(0));

    // Asynchronous reset between edges while the window is valid.
    #2;
    reset = 1'b0;
    #1;
    check("async_iv", 32'(bus.ivalid), 32'(0));
    check("async_rd", 32'(bus.mem_rd), 32'(0));
    check("async_data", 32'(bus.iread_data), 32'(0));
    enter_reset();
    release_reset(16'h4000);
    exp_q = '{16'h4000, 16'h4002, 16'h4004, 16'h4006};
    inj_late = 1'b1;
    apply(mk(16'h4000, 1, 1, 16'h4000, 0, 24'h000000), "rr0_late");
    apply(mk(16'h4000, 1, 1, 16'h4002, 0, 24'h000000), "rr1");
    apply(mk(16'h4000, 1, 1, 16'h4004, 0, 24'h000000), "rr2");
    apply(mk(16'h4000, 1, 1, 16'h4006, 1, 24'h020100), "rr3");
    check("sb_drain2", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
